boot_key_ctrl: RTL and testbench
================================

BOOT_KEY_CTRL -- requirements
Module: boot_key_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 240000, sets the stable-input cycles required before a level change is accepted (20 ms at 12 MHz).
REQ-002 Parameter LONG_PRESS_CYCLES, default 12000000, sets the debounced hold cycles that make a long press (1 s at 12 MHz).
REQ-003 Parameter KEY_ACTIVE_LOW, default 0: 0 means key_in=1 is pressed, 1 means key_in=0 is pressed.
REQ-004 Port clk, input, 1, single block clock (12 MHz quarter-speed clock); all logic on rising edge.
REQ-005 Port reset_n, input, 1, reset, asynchronous, active-low.
REQ-006 Port key_in, input, 1, raw asynchronous push-button pin.
REQ-007 Port boot_req_in, input, 1, synchronous warmboot request from the bootloader core, level.
REQ-008 Port boot_out, output, 1, sticky request driving SB_WARMBOOT BOOT.
REQ-009 Port key_level, output, 1, debounced key state, 1 = pressed.
REQ-010 Port press_pulse, output, 1, one-cycle strobe on debounced press.
REQ-011 Port short_press, output, 1, one-cycle strobe on debounced release when no long press occurred.
REQ-012 Port long_press, output, 1, one-cycle strobe when the hold reaches LONG_PRESS_CYCLES.

Function
REQ-013 key_in passes through a 2-flop synchronizer, then is XORed with KEY_ACTIVE_LOW to give key_sync (1 = pressed); no logic samples key_in directly.
REQ-014 The FSM has states IDLE, ARM, HELD, LONG and REL, with a debounce counter dcnt and a hold counter hcnt, each sized $clog2(param)+1 bits.
REQ-015 IDLE: when key_sync=1, go to ARM with dcnt=0.
REQ-016 ARM: when key_sync=0, return to IDLE.
REQ-017 ARM: otherwise dcnt increments; when dcnt==DEBOUNCE_CYCLES-1 with key_sync=1, go to HELD, set key_level=1, pulse press_pulse, clear hcnt and long_seen.
REQ-018 HELD: when key_sync=1, hcnt increments.
REQ-019 HELD: when hcnt==LONG_PRESS_CYCLES-1 with key_sync=1, go to LONG, pulse long_press, set long_seen=1.
REQ-020 HELD or LONG: when key_sync=0, go to REL with dcnt=0; hcnt freezes.
REQ-021 LONG: hcnt does not count; the FSM waits for release.
REQ-022 REL: when key_sync=1 (bounce), return to LONG if long_seen else HELD; hcnt resumes from its frozen value.
REQ-023 REL: when dcnt==DEBOUNCE_CYCLES-1 with key_sync=0, go to IDLE, clear key_level, and pulse short_press only if long_seen=0.
REQ-024 Press latency: press_pulse and key_level rise exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the new key_in level, given a clean input.
REQ-025 Release latency is symmetric to press latency.
REQ-026 Each strobe is high for exactly one cycle; press_pulse and short_press never assert together; long_press asserts at most once per press.
REQ-027 boot_out is set on the edge after long_press=1 or boot_req_in=1 is sampled, and stays 1 until reset_n is asserted.
REQ-028 Simultaneous boot_req_in and long_press give a single set of boot_out.
REQ-029 boot_req_in has no effect while boot_out=1.
REQ-030 Counters never wrap: dcnt and hcnt saturate at their terminal values.
REQ-031 Parameters DEBOUNCE_CYCLES and LONG_PRESS_CYCLES are each >= 2.

Reset
REQ-032 While reset_n=0: FSM=IDLE; dcnt, hcnt, long_seen and both synchronizer flops = 0 (post-XOR inactive level); all outputs = 0.
REQ-033 Reset asserted mid-press or mid-hold aborts without any strobe.
REQ-034 After reset release, a key already held goes through the full ARM debounce before press_pulse.
REQ-035 boot_out clears only on reset.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, KEY_ACTIVE_LOW=0)
REQ-036 Clean press: key_in 0->1 held 10 cycles -> press_pulse 1 cycle at edge 7, key_level=1 from edge 7, no other strobes.
REQ-037 Bounce: key_in toggles 1,0,1,0 one cycle each, then stays 0 -> no press_pulse, key_level stays 0, FSM back in IDLE.
REQ-038 Short press: hold 10 cycles, then release -> short_press 1 cycle, 7 edges after release, key_level falls on the same edge, boot_out=0.
REQ-039 Long press: hold 30 cycles -> long_press at 16 cycles after press_pulse, boot_out=1 on the next edge; after release no short_press; boot_out stays 1.
REQ-040 boot_req_in pulse 1 cycle with key idle -> boot_out=1 next edge; second pulse and key activity leave it at 1.
REQ-041 Reset mid-operation: reset_n low at hcnt=8 during a hold -> all outputs 0 immediately; after release with key still held, press_pulse again 7 edges later.

Source files
------------

// File: rtl/boot_key_ctrl.sv
// Boot key debouncer with press/short/long strobes and a sticky warmboot request.
// A long press or a bootloader request latches boot_out until reset.
module boot_key_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 240000,
    parameter int LONG_PRESS_CYCLES = 12000000,
    parameter int KEY_ACTIVE_LOW    = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_in,
    input  logic boot_req_in,
    output logic boot_out,
    output logic key_level,
    output logic press_pulse,
    output logic short_press,
    output logic long_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HMAX = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic KEY_IDLE = 1'(KEY_ACTIVE_LOW);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        HELD,
        LONG,
        REL
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] dcnt, dcnt_n, dcnt_inc;
    logic [HW-1:0] hcnt, hcnt_n, hcnt_inc;
    logic          long_seen, long_seen_n;
    logic          key_level_n, press_n, short_n, long_n;
    logic          sync1, sync2, key_sync;

    // Synchronizer flops rest at the raw idle level of the pin
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= KEY_IDLE;
            sync2 <= KEY_IDLE;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign key_sync = sync2 ^ KEY_IDLE;
    assign dcnt_inc = (dcnt == DMAX) ? dcnt : dcnt + DW'(1);
    assign hcnt_inc = (hcnt == HMAX) ? hcnt : hcnt + HW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            dcnt        <= '0;
            hcnt        <= '0;
            long_seen   <= 1'b0;
            key_level   <= 1'b0;
            press_pulse <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            boot_out    <= 1'b0;
        end else begin
            state       <= state_n;
            dcnt        <= dcnt_n;
            hcnt        <= hcnt_n;
            long_seen   <= long_seen_n;
            key_level   <= key_level_n;
            press_pulse <= press_n;
            short_press <= short_n;
            long_press  <= long_n;
            boot_out    <= boot_out | long_press | boot_req_in;
        end
    end

    always_comb begin
        state_n     = state;
        dcnt_n      = dcnt;
        hcnt_n      = hcnt;
        long_seen_n = long_seen;
        key_level_n = key_level;
        press_n     = 1'b0;
        short_n     = 1'b0;
        long_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_sync) begin
                    state_n = ARM;
                    dcnt_n  = '0;
                end
            end
            ARM: begin
                if (!key_sync) begin
                    state_n = IDLE;
                end else if (dcnt == DMAX) begin
                    state_n     = HELD;
                    key_level_n = 1'b1;
                    press_n     = 1'b1;
                    hcnt_n      = '0;
                    long_seen_n = 1'b0;
                end else begin
                    dcnt_n = dcnt_inc;
                end
            end
            HELD: begin
                if (!key_sync) begin
                    state_n = REL;
                    dcnt_n  = '0;
                end else if (hcnt == HMAX) begin
                    state_n     = LONG;
                    long_n      = 1'b1;
                    long_seen_n = 1'b1;
                end else begin
                    hcnt_n = hcnt_inc;
                end
            end
            LONG: begin
                if (!key_sync) begin
                    state_n = REL;
                    dcnt_n  = '0;
                end
            end
            REL: begin
                // A bounce back to pressed resumes the hold where it froze
                if (key_sync) begin
                    state_n = long_seen ? LONG : HELD;
                end else if (dcnt == DMAX) begin
                    state_n     = IDLE;
                    key_level_n = 1'b0;
                    short_n     = !long_seen;
                end else begin
                    dcnt_n = dcnt_inc;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_boot_key_ctrl.sv
// Directed bench for boot_key_ctrl with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_boot_key_ctrl;

    logic clk;
    logic reset_n;
    logic key_in;
    logic boot_req_in;
    logic boot_out;
    logic key_level;
    logic press_pulse;
    logic short_press;
    logic long_press;

    int total = 0;
    int bad   = 0;
    int n_pp  = 0;
    int n_sp  = 0;
    int n_lp  = 0;
    int n_ovl = 0;

    boot_key_ctrl #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(16),
        .KEY_ACTIVE_LOW   (0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_in     (key_in),
        .boot_req_in(boot_req_in),
        .boot_out   (boot_out),
        .key_level  (key_level),
        .press_pulse(press_pulse),
        .short_press(short_press),
        .long_press (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (press_pulse) n_pp++;
        if (short_press) n_sp++;
        if (long_press) n_lp++;
        if (press_pulse && short_press) n_ovl++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs packed as {boot_out,key_level,press,short,long}
    function automatic int outs();
        return int'({boot_out, key_level, press_pulse, short_press, long_press});
    endfunction

    initial begin
        reset_n     = 1'b0;
        key_in      = 1'b0;
        boot_req_in = 1'b0;
        step(3);
        chk("reset_outs", outs(), 0);
        reset_n = 1'b1;
        step(3);
        chk("idle_outs", outs(), 0);

        // Clean press then short release
        key_in = 1'b1;
        step(6);
        chk("press_e6", outs(), 5'b00000);
        step(1);
        chk("press_e7", outs(), 5'b01100);
        step(1);
        chk("press_e8", outs(), 5'b01000);
        step(2);
        key_in = 1'b0;
        step(6);
        chk("rel_e6", outs(), 5'b01000);
        step(1);
        chk("rel_e7", outs(), 5'b00010);
        step(1);
        chk("rel_e8", outs(), 5'b00000);
        chk("short_cnt", n_sp, 1);
        chk("lp_none", n_lp, 0);
        step(4);

        // Bounce never qualifies
        key_in = 1'b1; step(1);
        key_in = 1'b0; step(1);
        key_in = 1'b1; step(1);
        key_in = 1'b0; step(12);
        chk("bounce_outs", outs(), 0);
        chk("bounce_pp", n_pp, 1);

        // Long press
        key_in = 1'b1;
        step(7);
        chk("long_pp", outs(), 5'b01100);
        step(15);
        chk("long_e22", outs(), 5'b01000);
        step(1);
        chk("long_e23", outs(), 5'b01001);
        step(1);
        chk("long_e24", outs(), 5'b11000);
        step(6);
        key_in = 1'b0;
        step(6);
        chk("lrel_e6", outs(), 5'b11000);
        step(1);
        chk("lrel_e7", outs(), 5'b10000);
        step(3);
        chk("lrel_nosp", n_sp, 1);
        chk("long_once", n_lp, 1);

        // Reset clears boot_out
        reset_n = 1'b0;
        #2;
        chk("rst_boot", outs(), 0);
        step(1);
        reset_n = 1'b1;
        step(2);

        // boot_req_in sets boot_out on the next edge
        boot_req_in = 1'b1;
        step(1);
        chk("req_set", int'(boot_out), 1);
        boot_req_in = 1'b0;
        step(3);
        chk("req_hold", int'(boot_out), 1);
        boot_req_in = 1'b1;
        step(1);
        boot_req_in = 1'b0;
        key_in = 1'b1;
        step(10);
        key_in = 1'b0;
        step(8);
        chk("req_key", outs(), 5'b10000);
        chk("req_sp", n_sp, 2);

        // Reset during a hold at hcnt=8
        key_in = 1'b1;
        step(7);
        chk("mid_pp", outs(), 5'b11100);
        step(8);
        reset_n = 1'b0;
        #1;
        chk("mid_rst", outs(), 0);
        step(1);
        reset_n = 1'b1;
        step(6);
        chk("post_e6", outs(), 5'b00000);
        step(1);
        chk("post_e7", outs(), 5'b01100);
        key_in = 1'b0;
        step(10);
        chk("final_pp", n_pp, 5);
        chk("final_sp", n_sp, 3);
        chk("final_lp", n_lp, 1);
        chk("no_overlap", n_ovl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
